// File: rtl/sata_txarb_pkg.sv
// Shared SATA link-layer definitions for the transmit arbiter.
// Holds the transport TX word width, a few link primitive codes and the
// state encoding used by the transmit scheduler (sata_txarb).
package sata_txarb_pkg;

    // Transport-layer word width on the TX stream.
    localparam int DATA_W = 32;

    // Link primitive dwords (already in their 8b/10b-friendly K28.x form).
    localparam logic [DATA_W-1:0] SATA_PRIM_ALIGN = 32'h7B4A_4ABC;
    localparam logic [DATA_W-1:0] SATA_PRIM_SYNC  = 32'hB5B5_957C;
    localparam logic [DATA_W-1:0] SATA_PRIM_SOF   = 32'h3737_B57C;
    localparam logic [DATA_W-1:0] SATA_PRIM_EOF   = 32'hD5D5_B57C;

    // Transmit scheduler states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_WAIT  = 2'd3
    } txarb_state_t;

endpackage

// File: rtl/sata_txarb_rrpick.sv
// Two-way round-robin picker for the transmit arbiter.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset
//   i_req[1:0]       request vector {port1, port0}
//   i_update         load the pointer from the port just served
//   i_served_p1      1 when the served port was port 1, 0 for port 0
//   o_pick[1:0]      one-hot choice (combinational), 00 when no request
module satatx_rrpick
    import sata_txarb_pkg::*;
#(
    parameter int OPT_ROUND_ROBIN = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] i_req,
    input  logic       i_update,
    input  logic       i_served_p1,
    output logic [1:0] o_pick
);

    // Set when port 1 should win the next tie; after reset port 0 is favoured.
    logic favor_p1;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            favor_p1 <= 1'b0;
        else if (i_update)
            favor_p1 <= ~i_served_p1;
    end

    always_comb begin
        o_pick = i_req;
        if (i_req == 2'b11)
            o_pick = ((OPT_ROUND_ROBIN != 0) && favor_p1) ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/sata_txarb.sv
// Two-requester transmit scheduler in front of the link-layer TX stream.
// Whole FISes are granted to port 0 (command/register) or port 1 (data);
// the grant is held until the link reports success/failure, and that status
// is routed back to the owner. A WAIT timeout and a DRAIN state for FISes
// aborted mid-transfer keep requesters from hanging.
// Ports:
//   i_clk, i_reset              clock, asynchronous active-high reset
//   i_link_ready, i_link_error  link health / readiness
//   s0_* / s1_*                 requester streams plus success/failed pulses
//   m_*                         stream towards the link
//   i_success, i_failed         link status for the FIS in flight
//   o_grant                     one-hot owner, 00 in IDLE
//   o_busy                      scheduler not idle
//   o_timeout                   pulse when the WAIT timer expires
module sata_txarb
    import sata_txarb_pkg::*;
#(
    parameter int LGTIMEOUT       = 20,
    parameter int OPT_ROUND_ROBIN = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_link_ready,
    input  logic              i_link_error,

    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s0_last,
    output logic              s0_success,
    output logic              s0_failed,

    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [DATA_W-1:0] s1_data,
    input  logic              s1_last,
    output logic              s1_success,
    output logic              s1_failed,

    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,

    input  logic              i_success,
    input  logic              i_failed,

    output logic [1:0]        o_grant,
    output logic              o_busy,
    output logic              o_timeout
);

    txarb_state_t         state, next_state;
    logic [1:0]           grant_r;
    logic [LGTIMEOUT-1:0] timer;
    logic [1:0]           pick;

    logic g_valid, g_last;
    logic beat_last, drain_last, timer_full, abort;
    logic fail_pulse, succ_pulse, rr_update;

    // Granted-port stream fields; grant_r is one-hot or zero.
    assign g_valid    = grant_r[1] ? s1_valid : (grant_r[0] & s0_valid);
    assign g_last     = grant_r[1] ? s1_last  : s0_last;
    assign beat_last  = (state == ST_SEND)  && g_valid && m_ready && g_last;
    assign drain_last = (state == ST_DRAIN) && g_valid && g_last;
    assign timer_full = &timer;
    assign abort      = i_link_error || i_failed;
    assign rr_update  = (state != ST_IDLE) && (next_state == ST_IDLE);

    satatx_rrpick #(
        .OPT_ROUND_ROBIN (OPT_ROUND_ROBIN)
    ) u_rrpick (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_req       ({s1_valid, s0_valid}),
        .i_update    (rr_update),
        .i_served_p1 (grant_r[1]),
        .o_pick      (pick)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:
                if (i_link_ready && (s0_valid || s1_valid))
                    next_state = ST_SEND;
            ST_SEND:
                // An abort on the final beat has nothing left to drain.
                if (abort)
                    next_state = beat_last ? ST_IDLE : ST_DRAIN;
                else if (beat_last)
                    next_state = ST_WAIT;
            ST_DRAIN:
                if (drain_last)
                    next_state = ST_IDLE;
            ST_WAIT:
                if (i_success || abort || timer_full)
                    next_state = ST_IDLE;
            default:
                next_state = ST_IDLE;
        endcase
    end

    // Grant latch and WAIT timer.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            grant_r <= 2'b00;
            timer   <= '0;
        end else begin
            if (state == ST_IDLE && next_state == ST_SEND)
                grant_r <= pick;
            else if (next_state == ST_IDLE)
                grant_r <= 2'b00;

            if (state == ST_WAIT)
                timer <= timer + LGTIMEOUT'(1);
            else
                timer <= '0;
        end
    end

    // Outputs: stream muxing and status routing.
    always_comb begin
        fail_pulse = 1'b0;
        succ_pulse = 1'b0;
        o_timeout  = 1'b0;
        case (state)
            ST_SEND:  fail_pulse = abort && beat_last;
            ST_DRAIN: fail_pulse = drain_last;
            ST_WAIT: begin
                // Failure outranks a simultaneous success.
                fail_pulse = abort || timer_full;
                succ_pulse = i_success && !fail_pulse;
                o_timeout  = timer_full;
            end
            default: ;
        endcase

        s0_success = succ_pulse && grant_r[0];
        s0_failed  = fail_pulse && grant_r[0];
        s1_success = succ_pulse && grant_r[1];
        s1_failed  = fail_pulse && grant_r[1];

        m_valid  = (state == ST_SEND) && g_valid;
        m_data   = grant_r[1] ? s1_data : s0_data;
        m_last   = g_last;

        // DRAIN swallows the remainder of an aborted FIS.
        s0_ready = grant_r[0] && (((state == ST_SEND) && m_ready) || (state == ST_DRAIN));
        s1_ready = grant_r[1] && (((state == ST_SEND) && m_ready) || (state == ST_DRAIN));

        o_grant  = grant_r;
        o_busy   = (state != ST_IDLE);
    end

endmodule

// File: doc/sata_txarb.md
Name: sata_txarb

Overview:
- Two-requester transmit scheduler in front of the link layer's transport TX stream.
- Arbitrates whole FISes between port 0 (command/register FIS source) and port 1 (data FIS source).
- Holds the grant until the link reports success or failure for that FIS, then routes the status pulse back to the owning requester.
- Adds a response timeout and drains the rest of a FIS aborted mid-transfer, so a requester never hangs.

Parameters:
- LGTIMEOUT, 20: width of the status-wait counter; timeout fires after 2^LGTIMEOUT-1 cycles in WAIT.
- OPT_ROUND_ROBIN, 1: 1 = alternate priority when both request; 0 = port 0 always wins.

Ports:
- i_clk  input  1  single clock (link TX clock domain)
- i_reset  input  1  asynchronous, active-high reset
- i_link_ready  input  1  link synced, error-free, ready for a new FIS
- i_link_error  input  1  link error indication
- s0_valid / s0_ready / s0_data / s0_last  in/out/in/in  1/1/32/1  port 0 FIS stream
- s0_success / s0_failed  output  1 each  one-cycle status pulses for port 0
- s1_valid / s1_ready / s1_data / s1_last  in/out/in/in  1/1/32/1  port 1 FIS stream
- s1_success / s1_failed  output  1 each  one-cycle status pulses for port 1
- m_valid / m_ready / m_data / m_last  out/in/out/out  1/1/32/1  stream to the link
- i_success / i_failed  input  1 each  link status pulses for the current FIS
- o_grant  output  2  one-hot owner; 00 when IDLE
- o_busy  output  1  state != IDLE
- o_timeout  output  1  one-cycle pulse when the WAIT timer expires

Behaviour:
- Reset (asynchronous) values:
  - state IDLE, o_grant=00, all status pulses 0, o_timeout 0.
  - Round-robin pointer favours port 0; timer 0.
  - Reset mid-FIS produces no status pulse.
- Stream data path is combinational through the grant; no added latency:
  - m_valid = granted s_valid
  - m_data/m_last = granted port's fields
  - granted s_ready = m_ready
  - ungranted s_ready = 0
- IDLE:
  - If i_link_ready and any sN_valid, register the grant and enter SEND on the next cycle.
  - m_valid=0 and both s_ready=0 while in IDLE.
  - When both request: OPT_ROUND_ROBIN=1 picks the port not granted last; OPT_ROUND_ROBIN=0 picks port 0.
- SEND:
  - On m_valid&&m_ready&&m_last, go to WAIT with timer cleared.
  - i_link_error or i_failed while in SEND: go to DRAIN.
  - i_success in SEND is ignored.
- DRAIN:
  - m_valid=0; granted s_ready=1; words are discarded.
  - On granted s_valid&&s_last, pulse sN_failed and return to IDLE.
  - If the abort coincided with the last beat's handshake, skip DRAIN and pulse failed directly.
- WAIT:
  - m_valid=0; timer increments each cycle.
  - i_success → pulse sN_success, go to IDLE.
  - i_failed or i_link_error → pulse sN_failed, go to IDLE.
  - Timer reaches all-ones → pulse sN_failed and o_timeout together, go to IDLE.
  - Simultaneous i_success and i_failed: failed wins.
- Leaving SEND/WAIT/DRAIN: update the round-robin pointer to the served port; o_grant returns to 00 in IDLE.
- Status pulses last exactly one cycle and only ever go to the owner.
- No new grant is issued in the same cycle a status pulse is issued.
- A requester's valid dropping mid-FIS just stalls m_valid; there is no timeout in SEND.

Decomposition:
- Put the state encodings (IDLE, SEND, DRAIN, WAIT) in the shared SATA link header, alongside the primitive constants.
- One natural sub-module, satatx_rrpick: combinational two-way round-robin pick with a registered last-grant pointer.
- Everything else stays in sata_txarb.

Test Plan:
- Single FIS: port 0 sends 5 words, m_ready=1 throughout, i_success 3 cycles after last → m_data matches 5 words in order, s0_success pulses exactly 1 cycle, s1 outputs stay 0, o_grant=01 then 00.
- Contention: both ports valid at reset release with OPT_ROUND_ROBIN=1, each FIS 3 words → port 0 served first, then port 1, then port 0; with OPT_ROUND_ROBIN=0, port 0 is served twice in a row while it keeps requesting.
- Mid-FIS error: port 1 sends 8 words, i_link_error asserted after word 3 → m_valid drops, words 4–8 consumed with s1_ready=1, s1_failed pulses at the word-8 handshake, m never sees words 4–8.
- Timeout with LGTIMEOUT=4: FIS completes with no status → s0_failed and o_timeout pulse together exactly 15 cycles after entering WAIT.
- Simultaneous i_success and i_failed in WAIT → only sN_failed pulses; i_link_ready=0 with pending valid → no grant until ready rises.
- Asynchronous reset asserted in SEND mid-cycle → o_grant=00, m_valid=0, s_ready=0 immediately, no status pulse; clean FIS afterward succeeds.
